// File: rtl/masked_gf_pkg.sv
// Shared constants and helpers for the masked GF(2^4) datapath.
// Field is GF(2)[x]/(x^4+x+1). Operands are carried in the normal basis
// {b, b^2, b^4, b^8} with b = x^3; bit i is the coefficient of b^(2^i).
package masked_gf_pkg;

  localparam int GF_W = 4;

  localparam logic MODE_MUL     = 1'b0;
  localparam logic MODE_SQSCMUL = 1'b1;

  // Scaling constant of the square-scale map, normal basis.
  localparam logic [GF_W-1:0] SQSC_NU = 4'h8;

  // Mask index shared by the cross terms (i,j) and (j,i).
  function automatic int rand_idx(input int i, input int j, input int shares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Normal basis -> polynomial basis (b=1000, b^2=1100, b^4=1111, b^8=1010).
  function automatic logic [GF_W-1:0] nb_to_pb(input logic [GF_W-1:0] a);
    return (a[0] ? 4'b1000 : 4'b0000) ^ (a[1] ? 4'b1100 : 4'b0000) ^
           (a[2] ? 4'b1111 : 4'b0000) ^ (a[3] ? 4'b1010 : 4'b0000);
  endfunction

  // Inverse of nb_to_pb.
  function automatic logic [GF_W-1:0] pb_to_nb(input logic [GF_W-1:0] p);
    return {p[1] ^ p[0], p[0], p[2] ^ p[0], ^p};
  endfunction

  // Shift-and-add product modulo x^4+x+1.
  function automatic logic [GF_W-1:0] pb_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b);
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < GF_W; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[GF_W-2:0], 1'b0} ^ (sh[GF_W-1] ? 4'b0011 : 4'b0000);
    end
    return acc;
  endfunction

endpackage

// File: rtl/dom_cross_cell.sv
// One stage-1 DOM term with its enable flop. Domain cells may add the
// square-scale term; cross cells add their fresh mask (domain cells get 0).
module dom_cross_cell
  import masked_gf_pkg::*;
#(
  parameter bit DOMAIN = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_mode,
  input  logic [GF_W-1:0] i_x,
  input  logic [GF_W-1:0] i_y,
  input  logic [GF_W-1:0] i_z,
  output logic [GF_W-1:0] o_q
);

  logic [GF_W-1:0] w_prod;
  logic [GF_W-1:0] w_sqsc;
  logic [GF_W-1:0] w_term;
  logic [GF_W-1:0] r_q;

  gf2_mul #(.N(GF_W)) u_mul (
    .i_a (i_x),
    .i_b (i_y),
    .o_q (w_prod)
  );

  square_scaler u_sqsc (
    .i_a (i_x ^ i_y),
    .o_q (w_sqsc)
  );

  // Term to register: product, mask, and the square-scale part on the diagonal.
  always_comb begin
    w_term = w_prod ^ i_z;
    if (DOMAIN && (i_mode == MODE_SQSCMUL)) w_term = w_term ^ w_sqsc;
  end

  // Load only on accepted operations so stale and fresh masks never mix.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_q <= '0;
    else if (i_en) r_q <= w_term;
  end

  assign o_q = r_q;

endmodule

// File: rtl/gf2_mul.sv
// GF(2^4) multiplier, normal-basis operands and result.
module gf2_mul
  import masked_gf_pkg::*;
#(
  parameter int N = GF_W
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_q
);

  if (N != GF_W) begin : g_bad_width
    $error("gf2_mul: only the 4-bit field is provided");
  end

  assign o_q = pb_to_nb(pb_mul(nb_to_pb(i_a), nb_to_pb(i_b)));

endmodule

// File: rtl/square_scaler.sv
// sqsc(a) = NU * a^2 over GF(2^4), normal basis. Linear in a.
module square_scaler
  import masked_gf_pkg::*;
(
  input  logic [GF_W-1:0] i_a,
  output logic [GF_W-1:0] o_q
);

  logic [GF_W-1:0] w_sq;

  // Squaring in a normal basis is a cyclic shift of the coefficients.
  assign w_sq = {i_a[GF_W-2:0], i_a[GF_W-1]};

  gf2_mul #(.N(GF_W)) u_scale (
    .i_a (w_sq),
    .i_b (SQSC_NU),
    .o_q (o_q)
  );

endmodule

// File: rtl/shared_gf4_dom_mul_pipe.sv
// Pipelined DOM multiplier over GF(2^4) for SHARES shares, with optional
// square-scale term and optional registered output stage.
module shared_gf4_dom_mul_pipe
  import masked_gf_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int OUTREG = 0,
  parameter int NRAND  = SHARES * (SHARES - 1) / 2
) (
  input  logic                   ClkxCI,
  input  logic                   RstxBI,
  input  logic                   ValidxSI,
  input  logic                   ModexSI,
  input  logic [GF_W*SHARES-1:0] XxDI,
  input  logic [GF_W*SHARES-1:0] YxDI,
  input  logic [GF_W*NRAND-1:0]  ZxDI,
  output logic [GF_W*SHARES-1:0] QxDO,
  output logic                   ValidxSO
);

  if (SHARES < 2) begin : g_bad_shares
    $error("shared_gf4_dom_mul_pipe: SHARES must be at least 2");
  end

  logic [GF_W-1:0]        w_cell [SHARES][SHARES];
  logic [GF_W*SHARES-1:0] w_comp;

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
      logic [GF_W-1:0] w_z;
      if (gi == gj) begin : g_dom
        assign w_z = '0;
      end else begin : g_cross
        localparam int K = rand_idx(gi, gj, SHARES);
        assign w_z = ZxDI[GF_W*K +: GF_W];
      end
      dom_cross_cell #(.DOMAIN(gi == gj)) u_cell (
        .i_clk   (ClkxCI),
        .i_rst_n (RstxBI),
        .i_en    (ValidxSI),
        .i_mode  (ModexSI),
        .i_x     (XxDI[GF_W*gi +: GF_W]),
        .i_y     (YxDI[GF_W*gj +: GF_W]),
        .i_z     (w_z),
        .o_q     (w_cell[gi][gj])
      );
    end
  end

  // Output share i is the XOR of stage-1 row i; only registers feed it.
  always_comb begin
    w_comp = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        w_comp[GF_W*i +: GF_W] = w_comp[GF_W*i +: GF_W] ^ w_cell[i][j];
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [1:0]             r_vld;
    logic [GF_W*SHARES-1:0] r_q;

    // Two-deep valid pipe; output register loads behind a valid stage-1.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        r_vld <= '0;
        r_q   <= '0;
      end else begin
        r_vld <= {r_vld[0], ValidxSI};
        if (r_vld[0]) r_q <= w_comp;
      end
    end

    assign QxDO     = r_q;
    assign ValidxSO = r_vld[1];
  end else begin : g_noreg
    logic r_vld;

    // Single valid stage tracking the stage-1 cells.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) r_vld <= 1'b0;
      else         r_vld <= ValidxSI;
    end

    assign QxDO     = w_comp;
    assign ValidxSO = r_vld;
  end

endmodule

// File: doc/shared_gf4_dom_mul_pipe.md
# shared_gf4_dom_mul_pipe

Pipelined, valid-qualified Domain-Oriented-Masking (DOM) multiplier over GF(2^4) for an arbitrary number of shares, with a runtime mode that adds the square-scale term. It is the generic successor of the fixed two/three-share square-scale multiplier. It sits in the masked AES S-box inversion datapath, between the GF(2^4) split stage and the GF(2^4) inverter, and runs under a valid-pipeline flow. Fresh randomness is consumed only on accepted operations.

## Interface
- `SHARES`, default 2: number of shares, d+1. Legal range is ≥2; synthesis fails for values below 2.
- `OUTREG`, default 0: 1 adds a registered output stage after the share compression.
- `NRAND`, derived as SHARES*(SHARES-1)/2: number of 4-bit fresh masks per operation.
- `ClkxCI`, in, 1: clock.
- `RstxBI`, in, 1: reset, asynchronous, active-low.
- `ValidxSI`, in, 1: an operation is presented this cycle.
- `ModexSI`, in, 1: 0 selects Q = X·Y; 1 selects Q = X·Y ⊕ sqsc(X⊕Y).
- `XxDI`, in, 4*SHARES: shares of X. Share i occupies bits [4i+3:4i].
- `YxDI`, in, 4*SHARES: shares of Y, same packing as X.
- `ZxDI`, in, 4*NRAND: fresh masks. Mask k occupies bits [4k+3:4k].
- `QxDO`, out, 4*SHARES: shares of Q, same packing as X.
- `ValidxSO`, out, 1: QxDO holds the result of an accepted operation.

## Operation
- Pair (i,j) with i<j maps to mask index k(i,j) = i*SHARES − i*(i+1)/2 + (j−i−1). The same mask Z_k is used for both cross terms (i,j) and (j,i).
- Stage-1 register cells: SHARES² cells, 4 bits each.
  - Domain cell (i,i) loads Xi·Yi, XORed with sqsc(Xi⊕Yi) when ModexSI=1. No mask is added.
  - Cross cell (i,j), i≠j, loads Xi·Yj ⊕ Z_k(i,j).
- Enable rules for stage-1 cells:
  - All cells load only when ValidxSI=1 and hold otherwise. This prevents glitch recombination of stale and fresh masks.
  - The mode is sampled together with the data.
- Compression: output share i is the XOR of row i of the stage-1 cells. No combinational path exists from ZxDI to QxDO.
- `OUTREG=1`: the compressed shares pass through a register that loads only when the stage-1 valid bit is set.
- Valid pipeline:
  - The valid shift register is 1+OUTREG deep and loads unconditionally every cycle.
  - ValidxSO is the last bit of that shift register.
- Back-to-back operations are accepted every cycle. There is no stall or ready signal.
- Arithmetic:
  - Multiplication uses the codebase `gf2_mul` (N=4, normal basis).
  - sqsc uses `square_scaler`.
  - All XORs are 4-bit with no width growth.
  - The output bit order equals the input bit order. There is no rotation on QxDO.

## Timing
- Latency is 1+OUTREG cycles, from ValidxSI sampled high to ValidxSO high.
- Throughput is 1 operation per cycle.
- Reset (RstxBI=0, asynchronous):
  - All stage-1 cells, the output register and the valid shift register clear to 0 immediately.
  - QxDO = 0 and ValidxSO = 0 while reset is held.
  - An operation in flight when reset asserts is dropped and no valid is produced for it.
- First edge after reset release: ValidxSI is honoured on that edge.
- Idle cycles (ValidxSI=0): QxDO holds the last result share-for-share. ValidxSO deasserts after 1+OUTREG cycles.
- Mask usage: ZxDI must be fresh on every cycle with ValidxSI=1 and is ignored otherwise.

## Structure
- Shared package `masked_gf_pkg`:
  - Constants: GF width 4, mode encodings MODE_MUL=0 and MODE_SQSCMUL=1.
  - Function `rand_idx(i,j,shares)`.
- Sub-module `dom_cross_cell`: one 4-bit term with enable flop, instantiated SHARES² times with a DOMAIN parameter. `gf2_mul` and `square_scaler` are reused unchanged.

## Test plan
- SHARES=2, OUTREG=0, ModexSI=0, all shares and masks 0, ValidxSI pulse → ValidxSO high exactly 1 cycle later; QxDO = 0.
- SHARES=3, random X, Y, Z, both modes, 1000 back-to-back operations → unmasked Q equals the reference X·Y ⊕ (mode ? sqsc(X⊕Y) : 0) every cycle, for the value X=Y=4'h0.. and for all 256 (X,Y) pairs.
- ModexSI=1, X=Y (any value, e.g. 4'h9 with random sharing) → unmasked Q = X·X; the sqsc term contributes 0.
- OUTREG=1, ValidxSI = 1,0,1,1 → ValidxSO = 0,0,1,0,1,1 (two-cycle latency); QxDO is held during the gap.
- Reset asserted asynchronously mid-cycle with ValidxSI=1 → QxDO=0 and ValidxSO=0 without waiting for a clock edge; no valid appears after release.
- SHARES=4, ZxDI toggled with ValidxSI=0 → QxDO and all stage-1 cells unchanged (checked by assertion).
